dynamics_adsr: RTL and testbench

DYNAMICS_ADSR -- requirements
Module: dynamics_adsr

---
 rtl/dynamics_adsr.sv | 174 +++++++++++++++++
 tb/tb_dynamics_adsr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dynamics_adsr.sv
// ADSR envelope generator. Each sample strobe scales the input sample by the current gain.
// Build option DYNAMICS_LEGATO_EN: a note start keeps the current gain instead of reloading zero.
module dynamics_adsr #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 8,
  parameter int RATE_WIDTH   = 8,
  parameter int DUR_STROBES  = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_sample_ready,
  input  logic                           note_off,
  input  logic                           generate_next_sample,
  input  logic        [5:0]              note_duration,
  input  logic        [RATE_WIDTH-1:0]   attack_rate,
  input  logic        [RATE_WIDTH-1:0]   decay_rate,
  input  logic        [RATE_WIDTH-1:0]   release_rate,
  input  logic        [GAIN_WIDTH-1:0]   sustain_level,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic signed [SAMPLE_WIDTH-1:0] final_sample,
  output logic                           final_sample_valid,
  output logic        [2:0]              env_state
);

  // state   | meaning
  // IDLE    | silent, gain held at 0
  // ATTACK  | gain ramps up to full scale
  // DECAY   | gain ramps down to sustain_level
  // SUSTAIN | gain tracks sustain_level
  // RELEASE | gain ramps down to 0
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int DUR_SHIFT = $clog2(DUR_STROBES);
  localparam int DUR_W     = 6 + DUR_SHIFT;
  localparam int PROD_W    = SAMPLE_WIDTH + GAIN_WIDTH + 2;

  localparam logic [GAIN_WIDTH:0]   GAIN_FULL = {1'b1, {GAIN_WIDTH{1'b0}}};
  localparam logic [GAIN_WIDTH:0]   GAIN_ONE  = 1;
  localparam logic [RATE_WIDTH-1:0] RATE_ONE  = 1;
  localparam logic [DUR_W-1:0]      DUR_ONE   = 1;
  localparam logic [DUR_W-1:0]      DUR_MAX   = '1;

  state_t                    r_state, w_state_next;
  logic [GAIN_WIDTH:0]       r_gain, w_gain_next, w_sustain;
  logic [RATE_WIDTH-1:0]     r_rate_cnt, w_rate_next, w_rate_sel;
  logic [DUR_W-1:0]          r_dur_cnt, w_dur_next, w_dur_inc, w_dur_limit;
  logic                      w_active, w_expire, w_step;
  logic signed [PROD_W-1:0]  w_sample_ext, w_gain_ext, w_product;

  assign w_sample_ext = PROD_W'(sample);
  assign w_gain_ext   = PROD_W'(r_gain);
  assign w_product    = w_sample_ext * w_gain_ext;

  assign w_sustain   = {1'b0, sustain_level};
  assign w_active    = (r_state == S_ATTACK) || (r_state == S_DECAY) || (r_state == S_SUSTAIN);
  assign w_dur_limit = DUR_W'(note_duration) << DUR_SHIFT;
  // Saturates so a long held note never wraps into a spurious expiry.
  assign w_dur_inc   = (r_dur_cnt == DUR_MAX) ? r_dur_cnt : r_dur_cnt + DUR_ONE;
  assign w_expire    = generate_next_sample && w_active && (note_duration != 6'd0) &&
                       (w_dur_inc >= w_dur_limit);

  always_comb begin
    case (r_state)
      S_ATTACK:  w_rate_sel = attack_rate;
      S_DECAY:   w_rate_sel = decay_rate;
      S_RELEASE: w_rate_sel = release_rate;
      default:   w_rate_sel = '0;
    endcase
  end

  assign w_step = generate_next_sample && (r_rate_cnt == w_rate_sel);

  always_comb begin
    w_state_next = r_state;
    w_gain_next  = r_gain;
    w_rate_next  = r_rate_cnt;
    w_dur_next   = r_dur_cnt;
    if (new_sample_ready) begin
      w_state_next = S_ATTACK;
      w_rate_next  = '0;
      w_dur_next   = '0;
`ifdef DYNAMICS_LEGATO_EN
      w_gain_next  = r_gain;
`else
      w_gain_next  = '0;
`endif
    end else if ((note_off && w_active) || w_expire) begin
      // Forced release freezes gain on this edge; stepping resumes in RELEASE.
      w_state_next = S_RELEASE;
      w_rate_next  = '0;
      if (generate_next_sample) w_dur_next = w_dur_inc;
    end else begin
      if (generate_next_sample && w_active) w_dur_next = w_dur_inc;
      case (r_state)
        S_IDLE: begin
          w_gain_next = '0;
          w_rate_next = '0;
        end
        S_ATTACK: begin
          if (r_gain == GAIN_FULL) begin
            w_state_next = S_DECAY;
            w_rate_next  = '0;
          end else if (w_step) begin
            w_gain_next = r_gain + GAIN_ONE;
            w_rate_next = '0;
            if (w_gain_next == GAIN_FULL) w_state_next = S_DECAY;
          end else if (generate_next_sample) begin
            w_rate_next = r_rate_cnt + RATE_ONE;
          end
        end
        S_DECAY: begin
          if (r_gain <= w_sustain) begin
            w_state_next = S_SUSTAIN;
            w_rate_next  = '0;
          end else if (w_step) begin
            w_gain_next = r_gain - GAIN_ONE;
            w_rate_next = '0;
            if (w_gain_next == w_sustain) w_state_next = S_SUSTAIN;
          end else if (generate_next_sample) begin
            w_rate_next = r_rate_cnt + RATE_ONE;
          end
        end
        S_SUSTAIN: begin
          w_gain_next = w_sustain;
          w_rate_next = '0;
        end
        S_RELEASE: begin
          if (r_gain == '0) begin
            w_state_next = S_IDLE;
            w_rate_next  = '0;
          end else if (w_step) begin
            w_gain_next = r_gain - GAIN_ONE;
            w_rate_next = '0;
            if (w_gain_next == '0) w_state_next = S_IDLE;
          end else if (generate_next_sample) begin
            w_rate_next = r_rate_cnt + RATE_ONE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_gain_next  = '0;
          w_rate_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_gain             <= '0;
      r_rate_cnt         <= '0;
      r_dur_cnt          <= '0;
      final_sample       <= '0;
      final_sample_valid <= 1'b0;
    end else begin
      r_state            <= w_state_next;
      r_gain             <= w_gain_next;
      r_rate_cnt         <= w_rate_next;
      r_dur_cnt          <= w_dur_next;
      final_sample_valid <= generate_next_sample;
      if (generate_next_sample) final_sample <= SAMPLE_WIDTH'(w_product >>> GAIN_WIDTH);
    end
  end

  assign env_state = r_state;

endmodule

// File: tb/tb_dynamics_adsr.sv
// Bench for dynamics_adsr: directed vector table, hand-written corner sequences,
// then random stimulus compared cycle by cycle against an integer envelope model.
module tb_dynamics_adsr;

`ifdef DYNAMICS_LEGATO_EN
  localparam bit LEG = 1'b1;
`else
  localparam bit LEG = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic               new_sample_ready;
  logic               note_off;
  logic               generate_next_sample;
  logic        [5:0]  note_duration;
  logic        [7:0]  attack_rate;
  logic        [7:0]  decay_rate;
  logic        [7:0]  release_rate;
  logic        [7:0]  sustain_level;
  logic signed [15:0] sample;
  logic signed [15:0] final_sample;
  logic               final_sample_valid;
  logic        [2:0]  env_state;

  int total = 0;
  int bad   = 0;

  // reference model state: 0..4 envelope phase, gain 0..256
  int m_st = 0, m_gain = 0, m_rc = 0, m_dc = 0, e_fs = 0, e_v = 0;

  dynamics_adsr dut (
    .clk                  (clk),
    .reset                (reset),
    .new_sample_ready     (new_sample_ready),
    .note_off             (note_off),
    .generate_next_sample (generate_next_sample),
    .note_duration        (note_duration),
    .attack_rate          (attack_rate),
    .decay_rate           (decay_rate),
    .release_rate         (release_rate),
    .sustain_level        (sustain_level),
    .sample               (sample),
    .final_sample         (final_sample),
    .final_sample_valid   (final_sample_valid),
    .env_state            (env_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst, nsr, noff, gns;
    int dur, ar, dr, rr, sus, smp, reps;
    int efs, ev, est;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit nsr, bit noff, bit gns, int dur, int ar, int dr,
                              int rr, int sus, int smp, int reps, int efs, int ev, int est);
    vec_t v;
    v.rst = rst; v.nsr = nsr; v.noff = noff; v.gns = gns;
    v.dur = dur; v.ar = ar; v.dr = dr; v.rr = rr; v.sus = sus; v.smp = smp; v.reps = reps;
    v.efs = efs; v.ev = ev; v.est = est;
    return v;
  endfunction

  function automatic int fdiv256(longint p);
    longint q;
    q = p / 256;
    if (p < 0 && q * 256 != p) q = q - 1;
    return int'(q);
  endfunction

  task automatic drive(vec_t v);
    reset                = v.rst;
    new_sample_ready     = v.nsr;
    note_off             = v.noff;
    generate_next_sample = v.gns;
    note_duration        = 6'(v.dur);
    attack_rate          = 8'(v.ar);
    decay_rate           = 8'(v.dr);
    release_rate         = 8'(v.rr);
    sustain_level        = 8'(v.sus);
    sample               = 16'(v.smp);
  endtask

  task automatic model_edge();
    int  dinc, sus;
    bit  act, expire;
    if (reset) begin
      m_st = 0; m_gain = 0; m_rc = 0; m_dc = 0; e_fs = 0; e_v = 0;
      return;
    end
    sus = int'(sustain_level);
    e_v = generate_next_sample ? 1 : 0;
    if (generate_next_sample) e_fs = fdiv256(longint'(int'(sample)) * longint'(m_gain));
    act    = (m_st >= 1 && m_st <= 3);
    dinc   = (m_dc < 4095) ? m_dc + 1 : m_dc;
    expire = generate_next_sample && act && (note_duration != 0) &&
             (dinc >= int'(note_duration) * 64);
    if (new_sample_ready) begin
      m_st = 1; m_rc = 0; m_dc = 0;
      if (!LEG) m_gain = 0;
    end else if ((note_off && act) || expire) begin
      m_st = 4; m_rc = 0;
      if (generate_next_sample) m_dc = dinc;
    end else begin
      if (generate_next_sample && act) m_dc = dinc;
      case (m_st)
        0: begin m_gain = 0; m_rc = 0; end
        1: if (m_gain == 256) begin m_st = 2; m_rc = 0; end
           else if (generate_next_sample) begin
             if (m_rc == int'(attack_rate)) begin
               m_gain = m_gain + 1; m_rc = 0;
               if (m_gain == 256) m_st = 2;
             end else m_rc = m_rc + 1;
           end
        2: if (m_gain <= sus) begin m_st = 3; m_rc = 0; end
           else if (generate_next_sample) begin
             if (m_rc == int'(decay_rate)) begin
               m_gain = m_gain - 1; m_rc = 0;
               if (m_gain == sus) m_st = 3;
             end else m_rc = m_rc + 1;
           end
        3: begin m_gain = sus; m_rc = 0; end
        default: if (m_gain == 0) begin m_st = 0; m_rc = 0; end
           else if (generate_next_sample) begin
             if (m_rc == int'(release_rate)) begin
               m_gain = m_gain - 1; m_rc = 0;
               if (m_gain == 0) m_st = 0;
             end else m_rc = m_rc + 1;
           end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(string nm, int efs, int ev, int est);
    total++;
    if (int'(final_sample) != efs || int'(final_sample_valid) != ev || int'(env_state) != est) begin
      bad++;
      $display("FAIL %s: got fs=%0d valid=%0d state=%0d, want fs=%0d valid=%0d state=%0d",
               nm, final_sample, final_sample_valid, env_state, efs, ev, est);
    end
  endtask

  initial begin
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    //           rst nsr off gns dur ar dr rr sus  smp   reps  fs    v st
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 128, 10400, 3,   0,     0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 128, 10400, 1,   0,     0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 256, 10359, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 1,   10400, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 255, 5240,  1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 1,   5200,  1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 128, 10400, 1,   5200,  0, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 128, 10400, 1,   5200,  0, 4));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 128, 40,    1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 1,   0,     1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 128, 10400, 1,   0,     0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 128, 10400, 1,   0,     0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 128, 5159,  1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, -10400, 1,  -5200, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 1,   0,     0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 128, 10400, 1,   0,     0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, 10400, 1,   0,     1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 128, -10400, 1,  -41,   1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 128, 10400, 1,   0,     0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 1, 1, 0, 128, 10400, 1,   0,     0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2, 1, 1, 0, 128, 10400, 127, 2559,  1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2, 1, 1, 0, 128, 10400, 1,   2559,  1, 4));
    tbl.push_back(mk(0, 1, 1, 0, 2, 1, 1, 0, 128, 10400, 1,   2559,  0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      repeat (tbl[i].reps) tick();
      check($sformatf("vec%0d", i), tbl[i].efs, tbl[i].ev, tbl[i].est);
    end

    // RELEASE entered with zero gain drops to IDLE on the following edge.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); tick();
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); tick();
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); tick();
    check("rel_at_zero_enter", 0, 0, 4);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); tick();
    check("rel_at_zero_idle", 0, 0, 0);

    // Restart from RELEASE at gain 100; sample 256 makes the output equal the gain.
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); tick();
    drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); repeat (100) tick();
    check("leg_attack100", 99, 1, 1);
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); tick();
    check("leg_release", 99, 0, 4);
    drive(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); tick();
    check("leg_start_strobe", 100, 1, 1);
    drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0)); tick();
    check("leg_first", LEG ? 100 : 0, 1, 1);
    tick();
    check("leg_second", LEG ? 101 : 1, 1, 1);

    // Random phase; envelope settings change only in IDLE or under reset.
    drive(mk(1, 0, 0, 0, 0, 1, 2, 1, 64, 0, 1, 0, 0, 0));
    tick(); tick();
    check("rand_reset", 0, 0, 0);
    for (int c = 0; c < 6000; c++) begin
      reset = ($urandom_range(0, 699) == 0);
      if (reset || (m_st == 0 && $urandom_range(0, 9) == 0)) begin
        attack_rate   = 8'($urandom_range(0, 3));
        decay_rate    = 8'($urandom_range(0, 3));
        release_rate  = 8'($urandom_range(0, 3));
        sustain_level = 8'($urandom_range(0, 255));
        note_duration = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 2)) : 6'd0;
      end
      new_sample_ready     = ($urandom_range(0, 199) == 0);
      note_off             = ($urandom_range(0, 149) == 0);
      generate_next_sample = ($urandom_range(0, 1) == 1);
      sample               = 16'($urandom);
      tick();
      check($sformatf("rand%0d", c), e_fs, e_v, m_st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
